// File: rtl/muladd_seq.sv
// rtl/muladd_seq.sv - dot-product job sequencer driving an accumulate-mode MAC
// Optional feature macro: MULADD_SEQ_SAT_EN (clamp result to OUT_WIDTH range and flag it on res_sat)
module muladd_seq #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int C_WIDTH   = 20,
  parameter int Q_WIDTH   = 20,
  parameter int LEN_WIDTH = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 cmd_sign,
  input  logic [C_WIDTH-1:0]   cmd_bias,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [A_WIDTH-1:0]   op_a,
  input  logic [B_WIDTH-1:0]   op_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_WIDTH-1:0] res_data,
  output logic                 res_sat,
  output logic [A_WIDTH-1:0]   mac_A,
  output logic [B_WIDTH-1:0]   mac_B,
  output logic [C_WIDTH-1:0]   mac_C,
  output logic                 mac_ACC,
  output logic                 mac_clr,
  output logic                 mac_sign,
  input  logic [Q_WIDTH-1:0]   mac_Q
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic                 sign_q;
  logic [C_WIDTH-1:0]   bias_q;
  logic                 op_ready_w;
  logic                 op_fire;
  logic                 cmd_fire;
  logic                 last_op;

  // LOAD only accepts operands when the job actually has some
  assign op_ready_w = ((state == LOAD) && (len_q != '0)) || (state == RUN);
  assign op_fire    = op_valid & op_ready_w;
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign cnt_inc    = cnt + LEN_WIDTH'(1);
  assign last_op    = op_fire && (cnt_inc == len_q);

  // State register; async reset aborts any job in flight
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Job fields and operand counter
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      sign_q <= 1'b0;
      bias_q <= '0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (cmd_fire) begin
        len_q  <= cmd_len;
        sign_q <= cmd_sign;
        bias_q <= cmd_bias;
        cnt    <= '0;
      end
    end else if (op_fire) begin
      cnt <= cnt_inc;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_fire) state_nxt = LOAD;
      LOAD: state_nxt = ((len_q == '0) || last_op) ? DONE : RUN;
      RUN:  if (last_op) state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // MAC controls and handshake outputs; zero operands make the accumulator hold
  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    mac_C     = '0;
    mac_ACC   = 1'b0;
    mac_clr   = 1'b0;
    mac_sign  = 1'b0;
    op_ready  = op_ready_w;
    mac_A     = op_fire ? op_a : '0;
    mac_B     = op_fire ? op_b : '0;
    case (state)
      IDLE: begin
        cmd_ready = rst_n;
        mac_clr   = 1'b1;
      end
      LOAD: begin
        mac_C    = bias_q;
        mac_sign = sign_q;
      end
      RUN: begin
        mac_C    = bias_q;
        mac_sign = sign_q;
        mac_ACC  = 1'b1;
      end
      DONE: begin
        mac_C     = bias_q;
        mac_sign  = sign_q;
        mac_ACC   = 1'b1;
        res_valid = 1'b1;
      end
      default: mac_clr = 1'b1;
    endcase
  end

`ifdef MULADD_SEQ_SAT_EN
  localparam logic [Q_WIDTH-1:0] SMAX = {{(Q_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] SMIN = ~SMAX;
  localparam logic [Q_WIDTH-1:0] UMAX = {SMAX[Q_WIDTH-2:0], 1'b1};

  // Clamp the accumulator into the result range, signed or unsigned by job type
  always_comb begin
    res_data = '0;
    res_sat  = 1'b0;
    if (state == DONE) begin
      res_data = mac_Q[OUT_WIDTH-1:0];
      if (sign_q) begin
        if ($signed(mac_Q) > $signed(SMAX)) begin
          res_data = SMAX[OUT_WIDTH-1:0];
          res_sat  = 1'b1;
        end else if ($signed(mac_Q) < $signed(SMIN)) begin
          res_data = SMIN[OUT_WIDTH-1:0];
          res_sat  = 1'b1;
        end
      end else if (mac_Q > UMAX) begin
        res_data = UMAX[OUT_WIDTH-1:0];
        res_sat  = 1'b1;
      end
    end
  end
`else
  logic unused_q;
  assign unused_q = ^mac_Q;

  // Plain truncation of the accumulator; never reports clamping
  always_comb begin
    res_data = '0;
    res_sat  = 1'b0;
    if (state == DONE) res_data = mac_Q[OUT_WIDTH-1:0];
  end
`endif

endmodule

// File: tb/tb_muladd_seq.sv
// tb/tb_muladd_seq.sv - directed self-checking bench for muladd_seq with a behavioural MAC
module tb_muladd_seq;
  logic        CLK = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_sign;
  logic [7:0]  cmd_len;
  logic [19:0] cmd_bias;
  logic        op_valid, op_ready;
  logic [7:0]  op_a, op_b;
  logic        res_valid, res_ready, res_sat;
  logic [7:0]  res_data;
  logic [7:0]  mac_A, mac_B;
  logic [19:0] mac_C, mac_Q;
  logic        mac_ACC, mac_clr, mac_sign;

  int n_cmp = 0;
  int n_err = 0;

  muladd_seq #(.A_WIDTH(8), .B_WIDTH(8), .C_WIDTH(20), .Q_WIDTH(20), .LEN_WIDTH(8), .OUT_WIDTH(8)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_sign(cmd_sign), .cmd_bias(cmd_bias),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sat(res_sat),
    .mac_A(mac_A), .mac_B(mac_B), .mac_C(mac_C), .mac_ACC(mac_ACC), .mac_clr(mac_clr), .mac_sign(mac_sign),
    .mac_Q(mac_Q)
  );

  always #5 CLK = ~CLK;

  // Accumulate-mode MAC: Q <= (ACC ? Q : C) + A*B, operands extended by signExtension
  logic [19:0] a_x, b_x, prod_m, acc_m;
  assign a_x    = mac_sign ? {{12{mac_A[7]}}, mac_A} : {12'd0, mac_A};
  assign b_x    = mac_sign ? {{12{mac_B[7]}}, mac_B} : {12'd0, mac_B};
  assign prod_m = a_x * b_x;
  assign mac_Q  = acc_m;
  always @(posedge CLK) begin
    if (mac_clr) acc_m <= 20'd0;
    else         acc_m <= (mac_ACC ? acc_m : mac_C) + prod_m;
  end

  task automatic send_cmd(input logic [7:0] len, input logic sgn, input logic [19:0] bias);
    cmd_len = len; cmd_sign = sgn; cmd_bias = bias; cmd_valid = 1'b1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b);
    op_a = a; op_b = b; op_valid = 1'b1;
    @(posedge CLK); #1;
    op_valid = 1'b0; op_a = 8'd0; op_b = 8'd0;
  endtask

  task automatic finish_res();
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = 8'd0; cmd_sign = 1'b0; cmd_bias = 20'd0;
    op_valid = 1'b0; op_a = 8'd0; op_b = 8'd0; res_ready = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
    n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL rst_op_ready got %b exp 0", op_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
    n_cmp++; if (res_data !== 8'd0 || res_sat !== 1'b0) begin n_err++; $display("FAIL rst_res got %h/%b exp 00/0", res_data, res_sat); end
    n_cmp++; if ({mac_clr, mac_ACC, mac_sign} !== 3'b100) begin n_err++; $display("FAIL rst_mac_ctl got %b exp 100", {mac_clr, mac_ACC, mac_sign}); end
    n_cmp++; if (mac_A !== 8'd0 || mac_B !== 8'd0 || mac_C !== 20'd0) begin n_err++; $display("FAIL rst_mac_data got %h %h %h exp 0", mac_A, mac_B, mac_C); end
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL idle_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_unsigned();
    send_cmd(8'd3, 1'b0, 20'd5);
    n_cmp++; if (op_ready !== 1'b1 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL load_ready got op %b cmd %b exp 1 0", op_ready, cmd_ready); end
    do_op(8'd2, 8'd3);
    do_op(8'd4, 8'd5);
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL uns_early_valid got %b exp 0", res_valid); end
    do_op(8'd1, 8'd1);
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL uns_latency got res_valid %b exp 1", res_valid); end
    n_cmp++; if (res_data !== 8'd32 || res_sat !== 1'b0) begin n_err++; $display("FAIL uns_result got %0d/%b exp 32/0", res_data, res_sat); end
    n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL done_op_ready got %b exp 0", op_ready); end
    finish_res();
    n_cmp++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL uns_after got valid %b cmd_ready %b exp 0 1", res_valid, cmd_ready); end
  endtask

  task automatic test_bubbles();
    send_cmd(8'd2, 1'b1, 20'hFFFF6);
    do_op(8'hFD, 8'h04);
    n_cmp++; if (mac_sign !== 1'b1 || mac_C !== 20'hFFFF6) begin n_err++; $display("FAIL sgn_ctl got sign %b C %h exp 1 FFFF6", mac_sign, mac_C); end
    repeat (2) begin
      @(posedge CLK); #1;
    end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL sgn_bubble_valid got %b exp 0", res_valid); end
    do_op(8'h07, 8'hFE);
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL sgn_latency got res_valid %b exp 1", res_valid); end
    n_cmp++; if (res_data !== 8'hDC || res_sat !== 1'b0) begin n_err++; $display("FAIL sgn_result got %h/%b exp dc/0", res_data, res_sat); end
    finish_res();
  endtask

  task automatic test_len0();
    send_cmd(8'd0, 1'b0, 20'd123);
    op_valid = 1'b1; op_a = 8'd9; op_b = 8'd9;
    #1;
    n_cmp++; if (op_ready !== 1'b0 || mac_A !== 8'd0) begin n_err++; $display("FAIL len0_load got op_ready %b mac_A %h exp 0 00", op_ready, mac_A); end
    @(posedge CLK); #1;
    n_cmp++; if (res_valid !== 1'b1 || res_data !== 8'd123) begin n_err++; $display("FAIL len0_result got %b/%0d exp 1/123", res_valid, res_data); end
    n_cmp++; if (op_ready !== 1'b0 || mac_A !== 8'd0) begin n_err++; $display("FAIL len0_done got op_ready %b mac_A %h exp 0 00", op_ready, mac_A); end
    op_valid = 1'b0;
    finish_res();
  endtask

  task automatic test_backpressure();
    send_cmd(8'd1, 1'b0, 20'd0);
    do_op(8'd3, 8'd3);
    cmd_valid = 1'b1; cmd_len = 8'd1; cmd_sign = 1'b0; cmd_bias = 20'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      n_cmp++; if (res_valid !== 1'b1 || res_data !== 8'd9 || cmd_ready !== 1'b0) begin
        n_err++; $display("FAIL hold_%0d got valid %b data %0d cmd_ready %b exp 1 9 0", i, res_valid, res_data, cmd_ready);
      end
    end
    finish_res();
    n_cmp++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin n_err++; $display("FAIL post_hs got cmd_ready %b valid %b exp 1 0", cmd_ready, res_valid); end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b0 || op_ready !== 1'b1) begin n_err++; $display("FAIL late_accept got cmd_ready %b op_ready %b exp 0 1", cmd_ready, op_ready); end
    do_op(8'd2, 8'd2);
    n_cmp++; if (res_valid !== 1'b1 || res_data !== 8'd5) begin n_err++; $display("FAIL late_result got %b/%0d exp 1/5", res_valid, res_data); end
    finish_res();
  endtask

  task automatic test_reset_midjob();
    send_cmd(8'd4, 1'b1, 20'd7);
    do_op(8'd1, 8'd1);
    op_valid = 1'b1; op_a = 8'd5; op_b = 8'd5;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_hs got cmd %b op %b res %b exp 0 0 0", cmd_ready, op_ready, res_valid);
    end
    n_cmp++; if ({mac_clr, mac_ACC, mac_sign} !== 3'b100 || mac_A !== 8'd0 || mac_C !== 20'd0) begin
      n_err++; $display("FAIL abort_mac got ctl %b A %h C %h exp 100 00 00000", {mac_clr, mac_ACC, mac_sign}, mac_A, mac_C);
    end
    op_valid = 1'b0;
    @(posedge CLK); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin n_err++; $display("FAIL abort_idle got cmd %b res %b exp 1 0", cmd_ready, res_valid); end
    send_cmd(8'd1, 1'b0, 20'd0);
    do_op(8'd6, 8'd7);
    n_cmp++; if (res_valid !== 1'b1 || res_data !== 8'd42) begin n_err++; $display("FAIL after_abort got %b/%0d exp 1/42", res_valid, res_data); end
    finish_res();
  endtask

  task automatic test_saturation();
    logic       sg;
    logic [7:0] ln, a0, b0, a1, b1, e_d;
    logic [19:0] bs;
    logic       e_s;
    for (int k = 0; k < 5; k++) begin
      a1 = 8'd0; b1 = 8'd0; bs = 20'd0;
      case (k)
        0: begin sg = 1'b1; ln = 8'd1; a0 = 8'd127; b0 = 8'd127;
`ifdef MULADD_SEQ_SAT_EN
             e_d = 8'h7F; e_s = 1'b1;
`else
             e_d = 8'h01; e_s = 1'b0;
`endif
           end
        1: begin sg = 1'b1; ln = 8'd1; a0 = 8'h80; b0 = 8'd127;
`ifdef MULADD_SEQ_SAT_EN
             e_d = 8'h80; e_s = 1'b1;
`else
             e_d = 8'h80; e_s = 1'b0;
`endif
           end
        2: begin sg = 1'b1; ln = 8'd1; a0 = 8'h80; b0 = 8'd1; e_d = 8'h80; e_s = 1'b0; end
        3: begin sg = 1'b0; ln = 8'd2; a0 = 8'd255; b0 = 8'd255; a1 = 8'd1; b1 = 8'd1;
`ifdef MULADD_SEQ_SAT_EN
             e_d = 8'hFF; e_s = 1'b1;
`else
             e_d = 8'h02; e_s = 1'b0;
`endif
           end
        default: begin sg = 1'b0; ln = 8'd1; a0 = 8'd0; b0 = 8'd0; bs = 20'd255; e_d = 8'hFF; e_s = 1'b0; end
      endcase
      send_cmd(ln, sg, bs);
      do_op(a0, b0);
      if (ln == 8'd2) do_op(a1, b1);
      n_cmp++; if (res_valid !== 1'b1 || res_data !== e_d || res_sat !== e_s) begin
        n_err++; $display("FAIL sat_case_%0d got %b/%h/%b exp 1/%h/%b", k, res_valid, res_data, res_sat, e_d, e_s);
      end
      finish_res();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_bubbles();
    test_len0();
    test_backpressure();
    test_reset_midjob();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule
